// File: rtl/i2c_cmd_sequencer_if.sv
// ============================================================================
//  Module   : i2c_cmd_sequencer_if
//  Brief    : Command handshake and open-drain pad bundle between the
//             instruction decoder / core and the I2C command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_cmd_sequencer_if;
  // Core-side command handshake
  logic       i_valid;
  logic [2:0] i_cmd;
  logic [7:0] i_data;
  // Pad inputs
  logic       i_sda;
  logic       i_scl;
  // Pad controls and status back to the core
  logic       o_scl;
  logic       o_sda_oe;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;

  // Sequencer side
  modport slave (
    input  i_valid, i_cmd, i_data, i_sda, i_scl,
    output o_scl, o_sda_oe, o_busy, o_done, o_ack_err
  );

  // Core / pad side
  modport master (
    output i_valid, i_cmd, i_data, i_sda, i_scl,
    input  o_scl, o_sda_oe, o_busy, o_done, o_ack_err
  );
endinterface

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
//  Module   : i2c_cmd_sequencer
//  Brief    : Turns START / STOP / SENDCON / SENDI2C control codes into
//             quarter-phase I2C waveforms on open-drain SCL/SDA, one command
//             at a time, reporting busy, done and slave NACK.
//  Options  : I2C_CLK_STRETCH_EN - freeze timing while a slave holds SCL low
//             in the phases where SCL is released after being driven low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_sequencer #(
  parameter int unsigned CLK_DIV    = 25,     // system clocks per quarter SCL period
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C   // address sent by SENDCON (write)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  i2c_cmd_sequencer_if.slave   bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] C_CMD_START   = 3'b001;
  localparam logic [2:0] C_CMD_STOP    = 3'b010;
  localparam logic [2:0] C_CMD_SENDCON = 3'b011;
  localparam logic [2:0] C_CMD_SENDI2C = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BYTE  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [1:0]       ph_q,     ph_d;
  logic [3:0]       bit_q,    bit_d;
  logic [7:0]       data_q,   data_d;
  logic             scl_q,    scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic             done_q,   done_d;
  logic             ack_err_q, ack_err_d;

  logic w_div_end;
  logic w_stall;

  assign w_div_end = (div_q == C_DIV_LAST);

`ifdef I2C_CLK_STRETCH_EN
  // Only the SCL-release phases can be stretched by a slave.
  assign w_stall = ((state_q == S_BYTE) || (state_q == S_STOP)) &&
                   (ph_q == 2'd1) && !bus.i_scl;
`else
  logic w_unused_scl;
  assign w_unused_scl = bus.i_scl;
  assign w_stall      = 1'b0;
`endif

  // Next-state: command acceptance, divider/phase/bit sequencing, ACK sample,
  // then pad levels derived from the upcoming state so outputs are registered.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        ph_d  = 2'd0;
        bit_d = 4'd0;
        if (bus.i_valid) begin
          case (bus.i_cmd)
            C_CMD_START: state_d = S_START;
            C_CMD_STOP:  state_d = S_STOP;
            C_CMD_SENDCON: begin
              state_d   = S_BYTE;
              data_d    = {SLAVE_ADDR, 1'b0};
              ack_err_d = 1'b0;
            end
            C_CMD_SENDI2C: begin
              state_d   = S_BYTE;
              data_d    = bus.i_data;
              ack_err_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (!w_stall) begin
          if (w_div_end) begin
            div_d = '0;
            ph_d  = ph_q + 2'd1;
            // ACK is sampled on the final clock of the SCL-high quarter.
            if ((state_q == S_BYTE) && (bit_q == 4'd8) && (ph_q == 2'd1))
              ack_err_d = bus.i_sda;
            if (ph_q == 2'd3) begin
              if ((state_q == S_BYTE) && (bit_q != 4'd8)) begin
                bit_d  = bit_q + 4'd1;
                data_d = {data_q[6:0], 1'b0};
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                bit_d   = 4'd0;
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
    endcase

    // Pad levels; IDLE holds whatever the last command left on the bus.
    case (state_d)
      S_START: begin
        scl_d    = (ph_d != 2'd3);
        sda_oe_d = (ph_d != 2'd0);
      end
      S_BYTE: begin
        scl_d    = (ph_d == 2'd1) || (ph_d == 2'd2);
        sda_oe_d = (bit_d == 4'd8) ? 1'b0 : ~data_d[7];
      end
      S_STOP: begin
        scl_d    = (ph_d != 2'd0);
        sda_oe_d = (ph_d < 2'd2);
      end
      default: ;
    endcase
  end

  // State register; reset releases the bus without issuing a STOP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      ph_q      <= 2'd0;
      bit_q     <= 4'd0;
      data_q    <= 8'h00;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.o_scl     = scl_q;
  assign bus.o_sda_oe  = sda_oe_q;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_done    = done_q;
  assign bus.o_ack_err = ack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_i2c_cmd_sequencer
//  Brief    : Directed bench for i2c_cmd_sequencer with a done-driven
//             scoreboard (CLK_DIV = 2, so one SCL period is 8 clocks).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_sequencer;

  localparam int unsigned CLK_DIV = 2;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH = 10;
`else
  localparam int STRETCH = 0;
`endif

  typedef struct {
    int         lat;      // busy cycles
    logic       ack;      // o_ack_err after done
    logic       is_byte;
    logic [7:0] bits;     // SDA seen on the first 8 SCL rising edges
    int         nst;      // SDA falls while SCL high
    int         nsp;      // SDA rises while SCL high
    logic       scl;      // final SCL
    logic       oe;       // final SDA drive
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic slave_pull = 1'b0;
  logic force_low  = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  exp_t q[$];

  i2c_cmd_sequencer_if bus ();

  assign bus.i_sda = ~(bus.o_sda_oe | slave_pull);
  assign bus.i_scl = force_low ? 1'b0 : bus.o_scl;

  i2c_cmd_sequencer #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h3C)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int lat, input logic ack, input logic isb,
                      input logic [7:0] bits, input int nst, input int nsp,
                      input logic scl, input logic oe);
    exp_t e;
    e.lat = lat; e.ack = ack; e.is_byte = isb; e.bits = bits;
    e.nst = nst; e.nsp = nsp; e.scl = scl; e.oe = oe;
    q.push_back(e);
  endtask

  // Monitor: accumulates bus activity and scores each command on o_done.
  int         busy_cnt = 0;
  int         nbits    = 0;
  logic [7:0] bits     = 8'h00;
  int         nst      = 0;
  int         nsp      = 0;
  logic       prev_scl = 1'b1;
  logic       prev_oe  = 1'b0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      busy_cnt = 0; nbits = 0; bits = 8'h00; nst = 0; nsp = 0;
      prev_scl = 1'b1; prev_oe = 1'b0;
    end else begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_busy && !prev_scl && bus.o_scl && nbits < 8) begin
        bits = {bits[6:0], ~bus.o_sda_oe};
        nbits++;
      end
      if (prev_scl && bus.o_scl && !prev_oe && bus.o_sda_oe) nst++;
      if (prev_scl && bus.o_scl && prev_oe && !bus.o_sda_oe) nsp++;
      if (bus.o_done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no done");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", busy_cnt, e.lat);
          chk("ack_err", int'(bus.o_ack_err), int'(e.ack));
          chk("start_cond", nst, e.nst);
          chk("stop_cond", nsp, e.nsp);
          chk("final_scl", int'(bus.o_scl), int'(e.scl));
          chk("final_sda_oe", int'(bus.o_sda_oe), int'(e.oe));
          if (e.is_byte) chk("byte_bits", int'(bits), int'(e.bits));
        end
        busy_cnt = 0; nbits = 0; bits = 8'h00; nst = 0; nsp = 0;
      end
      prev_scl = bus.o_scl;
      prev_oe  = bus.o_sda_oe;
    end
  end

  // Called at a negedge; holds i_valid across one rising edge.
  task automatic issue(input logic [2:0] cmd, input logic [7:0] data);
    bus.i_valid = 1'b1;
    bus.i_cmd   = cmd;
    bus.i_data  = data;
    @(negedge i_clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge i_clk);
      if (bus.o_done) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within 300 clocks", name);
    end
  endtask

  initial begin
    bit found;
    int rises;
    logic pscl;

    bus.i_valid = 1'b0;
    bus.i_cmd   = 3'b000;
    bus.i_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_scl",     int'(bus.o_scl),     1);
    chk("rst_sda_oe",  int'(bus.o_sda_oe),  0);
    chk("rst_busy",    int'(bus.o_busy),    0);
    chk("rst_done",    int'(bus.o_done),    0);
    chk("rst_ack_err", int'(bus.o_ack_err), 0);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);

    // START, with a second START during busy that must be ignored
    push(8, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0, 1'b1);
    issue(3'b001, 8'h00);
    repeat (2) @(negedge i_clk);
    issue(3'b001, 8'h00);
    wait_done("start");

    // SENDCON, slave ACKs
    slave_pull = 1'b1;
    push(72, 1'b0, 1'b1, 8'h78, 0, 0, 1'b0, 1'b0);
    issue(3'b011, 8'hFF);
    wait_done("sendcon");
    slave_pull = 1'b0;

    // SENDI2C 0xA5, slave NACKs
    push(72, 1'b1, 1'b1, 8'hA5, 0, 0, 1'b0, 1'b0);
    issue(3'b100, 8'hA5);
    wait_done("sendi2c_nack");

    // STOP keeps the NACK flag and releases the bus
    push(8, 1'b1, 1'b0, 8'h00, 0, 1, 1'b1, 1'b0);
    issue(3'b010, 8'h00);
    wait_done("stop");

    // Illegal codes: no busy, no done
    issue(3'b111, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("illegal_busy", int'(bus.o_busy), 0);
      @(negedge i_clk);
    end
    issue(3'b000, 8'h00);
    chk("illegal0_busy", int'(bus.o_busy), 0);
    chk("illegal_ack_hold", int'(bus.o_ack_err), 1);

    // START then SENDI2C 0x3C with SCL held low by the slave in bit 3 ph1
    push(8, 1'b1, 1'b0, 8'h00, 1, 0, 1'b0, 1'b1);
    issue(3'b001, 8'h00);
    wait_done("start2");
    slave_pull = 1'b1;
    push(72 + STRETCH, 1'b0, 1'b1, 8'h3C, 0, 0, 1'b0, 1'b0);
    issue(3'b100, 8'h3C);
    found = 1'b0;
    rises = 0;
    pscl  = bus.o_scl;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge i_clk);
      if (!pscl && bus.o_scl) rises++;
      pscl = bus.o_scl;
      if (rises == 4) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_fail++;
      $display("FAIL bit3_rise: got %0d SCL rises, expected 4", rises);
    end
    force_low = 1'b1;
    repeat (10) @(negedge i_clk);
    force_low = 1'b0;
    wait_done("stretch");
    slave_pull = 1'b0;

    // Asynchronous reset in the middle of a byte (SCL low, SDA driven)
    issue(3'b100, 8'h00);
    repeat (22) @(negedge i_clk);
    chk("pre_rst_scl",    int'(bus.o_scl),    0);
    chk("pre_rst_sda_oe", int'(bus.o_sda_oe), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_scl",     int'(bus.o_scl),     1);
    chk("mid_rst_sda_oe",  int'(bus.o_sda_oe),  0);
    chk("mid_rst_busy",    int'(bus.o_busy),    0);
    chk("mid_rst_done",    int'(bus.o_done),    0);
    chk("mid_rst_ack_err", int'(bus.o_ack_err), 0);
    q.delete();
    repeat (2) @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);

    // Recovery after reset
    push(8, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0, 1'b1);
    issue(3'b001, 8'h00);
    wait_done("start_after_rst");

    repeat (5) @(negedge i_clk);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
